// File: rtl/chess_pkg.sv
// Shared move-generator definitions: board geometry, piece codes,
// row constants and the dispatcher state enumeration.
package chess_pkg;

  localparam int NCOL = 8;
  localparam int NROW = 8;
  localparam int SQW  = 4;
  localparam int COLW = NROW * SQW;

  typedef enum logic [2:0] {
    EMPTY  = 3'o0,
    PAWN   = 3'o1,
    KNIGHT = 3'o2,
    BISHOP = 3'o3,
    ROOK   = 3'o4,
    QUEEN  = 3'o5,
    KING   = 3'o6
  } piece_t;

  localparam int COLOR_BIT = 3;

  localparam logic [2:0] ROW1 = 3'd0;
  localparam logic [2:0] ROW2 = 3'd1;
  localparam logic [2:0] ROW3 = 3'd2;
  localparam logic [2:0] ROW4 = 3'd3;
  localparam logic [2:0] ROW5 = 3'd4;
  localparam logic [2:0] ROW6 = 3'd5;
  localparam logic [2:0] ROW7 = 3'd6;
  localparam logic [2:0] ROW8 = 3'd7;

  localparam logic [8:0] PVOID = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ARM,
    WAIT
  } disp_state_t;

endpackage

// File: rtl/board_dispatcher_if.sv
// Controller-to-dispatcher board handshake.
interface board_dispatcher_if;
  import chess_pkg::*;

  logic                      brd_valid;
  logic                      brd_ready;
  logic [NCOL*COLW-1:0]      brd_data;
  logic                      brd_side;

  modport master (
    output brd_valid,
    output brd_data,
    output brd_side,
    input  brd_ready
  );

  modport slave (
    input  brd_valid,
    input  brd_data,
    input  brd_side,
    output brd_ready
  );

endinterface

// File: rtl/board_dispatcher_sweep_timer.sv
// WAIT-state cycle counter with settle window and timeout detect.
module sweep_timer #(
  parameter int SETTLE    = 2,
  parameter int TO_CYCLES = 1023,
  parameter int CNTW      = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic settle_ok,
  output logic expired
);

  logic [CNTW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign settle_ok = cnt >= CNTW'(SETTLE);
  assign expired   = cnt == CNTW'(TO_CYCLES);

endmodule

// File: rtl/board_dispatcher.sv
// Streams one board into the column units and waits for the sweep.
module board_dispatcher
  import chess_pkg::*;
#(
  parameter int SETTLE    = 2,
  parameter int TO_CYCLES = 1023,
  parameter int CNTW      = 10
) (
  input  logic                clk,
  input  logic                rst,
  board_dispatcher_if.slave   brd,
  output logic [COLW-1:0]     col_bstate,
  output logic [NCOL-1:0]     col_load,
  output logic                col_side,
  output logic                newboard,
  input  logic [NCOL-1:0]     col_done,
  output logic                sweep_done,
  output logic                sweep_timeout,
  output logic                busy
);

  localparam int CIW = $clog2(NCOL);

  disp_state_t          state;
  disp_state_t          state_n;
  logic [NCOL*COLW-1:0] buf_q;
  logic [CIW-1:0]       col;
  logic                 accept;
  logic                 settle_ok;
  logic                 expired;
  logic                 fin;

  assign accept = (state == IDLE) && brd.brd_valid && brd.brd_ready;
  assign fin    = settle_ok && (&col_done);

  sweep_timer #(
    .SETTLE    (SETTLE),
    .TO_CYCLES (TO_CYCLES),
    .CNTW      (CNTW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == ARM),
    .en        (state == WAIT),
    .settle_ok (settle_ok),
    .expired   (expired)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = LOAD;
      LOAD: if (col == CIW'(NCOL - 1)) state_n = ARM;
      ARM:  state_n = WAIT;
      WAIT: if (fin || expired) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      buf_q         <= '0;
      col           <= '0;
      col_side      <= 1'b0;
      col_bstate    <= '0;
      col_load      <= '0;
      newboard      <= 1'b0;
      sweep_done    <= 1'b0;
      sweep_timeout <= 1'b0;
      busy          <= 1'b0;
      brd.brd_ready <= 1'b0;
    end else begin
      state         <= state_n;
      // ready never overlaps the accepting edge, so one board per handshake
      brd.brd_ready <= (state == IDLE) && !accept;
      busy          <= state_n != IDLE;
      col_load      <= '0;
      newboard      <= state == ARM;
      sweep_done    <= (state == WAIT) && fin;
      sweep_timeout <= (state == WAIT) && !fin && expired;
      if (accept) begin
        buf_q    <= brd.brd_data;
        col_side <= brd.brd_side;
        col      <= '0;
      end
      if (state == LOAD) begin
        col_bstate <= buf_q[int'(col)*COLW +: COLW];
        col_load   <= NCOL'(1) << col;
        col        <= col + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_board_dispatcher.sv
// Randomized scoreboard bench for board_dispatcher.
module tb_board_dispatcher;
  import chess_pkg::*;

  localparam int SETTLE = 2;
  localparam int TO     = 1023;
  localparam int CNTW   = 10;
  localparam int NEVER  = 1 << 28;

  localparam int K_LOAD = 0;
  localparam int K_NB   = 1;
  localparam int K_DONE = 2;
  localparam int K_TO   = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [COLW-1:0] col_bstate;
  logic [NCOL-1:0] col_load;
  logic [NCOL-1:0] col_done;
  logic            col_side;
  logic            newboard;
  logic            sweep_done;
  logic            sweep_timeout;
  logic            busy;

  board_dispatcher_if bif();

  board_dispatcher #(
    .SETTLE    (SETTLE),
    .TO_CYCLES (TO),
    .CNTW      (CNTW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .brd           (bif.slave),
    .col_bstate    (col_bstate),
    .col_load      (col_load),
    .col_side      (col_side),
    .newboard      (newboard),
    .col_done      (col_done),
    .sweep_done    (sweep_done),
    .sweep_timeout (sweep_timeout),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              kind;
    int              cyc;
    int              col;
    logic [COLW-1:0] data;
    logic            side;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;

  logic [3:0] bsq [NCOL][NROW];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind);
    ev_t e;
    int  idx;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event kind=%0d at cycle %0d: actual=1 required=0",
               kind, cyc);
      return;
    end
    e = q.pop_front();
    chk("event_kind", 64'(kind), 64'(e.kind));
    chk("event_cycle", 64'(cyc), 64'(e.cyc));
    if (kind == K_LOAD) begin
      idx = -1;
      for (int i = 0; i < NCOL; i++) if (col_load[i]) idx = i;
      chk("col_load_onehot", 64'($countones(col_load)), 64'd1);
      chk("col_load_index", 64'(idx), 64'(e.col));
      chk("col_bstate", 64'(col_bstate), 64'(e.data));
      chk("col_side", 64'(col_side), 64'(e.side));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (col_load != '0) expect_ev(K_LOAD);
      if (newboard)       expect_ev(K_NB);
      if (sweep_done)     expect_ev(K_DONE);
      if (sweep_timeout)  expect_ev(K_TO);
    end
  end

  function automatic logic [7:0] partial();
    logic [7:0] v;
    v = 8'($urandom);
    v[$urandom_range(0, 7)] = 1'b0;
    return v;
  endfunction

  function automatic logic [COLW-1:0] model_col(input int c);
    logic [COLW-1:0] w;
    w = '0;
    for (int r = 0; r < NROW; r++) w[r*SQW +: SQW] = bsq[c][r];
    return w;
  endfunction

  task automatic fill_pattern();
    for (int c = 0; c < NCOL; c++)
      for (int r = 0; r < NROW; r++)
        bsq[c][r] = 4'(((c & 1) << 3) | r);
  endtask

  task automatic fill_random();
    for (int c = 0; c < NCOL; c++)
      for (int r = 0; r < NROW; r++)
        bsq[c][r] = {1'($urandom), 3'($urandom_range(0, 6))};
  endtask

  task automatic drive_board(input logic side, output int h);
    int k;
    k = 0;
    while (!bif.brd_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_send", 64'(bif.brd_ready), 64'd1);
    for (int c = 0; c < NCOL; c++)
      for (int r = 0; r < NROW; r++)
        bif.brd_data[c*COLW + r*SQW +: SQW] = bsq[c][r];
    bif.brd_side  = side;
    bif.brd_valid = 1'b1;
    @(negedge clk);
    h = cyc;
    chk("ready_drop", 64'(bif.brd_ready), 64'd0);
    chk("busy_after_accept", 64'(busy), 64'd1);
    for (int c = 0; c < NCOL; c++) begin
      ev_t e;
      e.kind = K_LOAD;
      e.cyc  = h + 1 + c;
      e.col  = c;
      e.data = model_col(c);
      e.side = side;
      q.push_back(e);
    end
  endtask

  // d: first cycle index after newboard at which all columns report done
  task automatic run_board(input logic side, input int d, input bit stale,
                           input bit hold_other);
    int  h;
    int  n;
    int  e_cyc;
    bit  got;
    ev_t e;
    col_done = stale ? '1 : partial();
    drive_board(side, h);
    n = h + 9;
    e.kind = K_NB; e.cyc = n; e.col = 0; e.data = '0; e.side = side;
    q.push_back(e);
    e_cyc = n + ((d > SETTLE + 1) ? d : SETTLE + 1);
    if (e_cyc > n + TO + 1) begin
      e.kind = K_TO;
      e.cyc  = n + TO + 1;
    end else begin
      e.kind = K_DONE;
      e.cyc  = e_cyc;
    end
    q.push_back(e);
    if (hold_other) begin
      bif.brd_data = {8{32'($urandom)}};
      bif.brd_side = ~side;
    end else begin
      bif.brd_valid = 1'b0;
    end
    while (cyc < n) @(negedge clk);
    got = 1'b0;
    for (int j = 1; j <= TO + 3; j++) begin
      col_done = (j >= d || (stale && j <= SETTLE)) ? '1 : partial();
      @(negedge clk);
      if (sweep_done || sweep_timeout) begin
        got = 1'b1;
        break;
      end
    end
    bif.brd_valid = 1'b0;
    chk("end_pulse_seen", 64'(got), 64'd1);
    chk("busy_at_end", 64'(busy), 64'd0);
    @(negedge clk);
    chk("ready_after_end", 64'(bif.brd_ready), 64'd1);
    chk("pulse_single", 64'(sweep_done | sweep_timeout), 64'd0);
  endtask

  task automatic run_reset_mid_load();
    int h;
    col_done = partial();
    fill_random();
    drive_board(1'b1, h);
    bif.brd_valid = 1'b0;
    while (cyc < h + 5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_col_load", 64'(col_load), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(bif.brd_ready), 64'd0);
    chk("rst_newboard", 64'(newboard), 64'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    chk("post_rst_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog at cycle %0d: actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bif.brd_valid = 1'b0;
    bif.brd_side  = 1'b0;
    bif.brd_data  = '0;
    col_done      = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(bif.brd_ready), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_col_load", 64'(col_load), 64'd0);
    chk("reset_bstate", 64'(col_bstate), 64'd0);
    chk("reset_side", 64'(col_side), 64'd0);
    chk("reset_pulses", 64'({newboard, sweep_done, sweep_timeout}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", 64'(bif.brd_ready), 64'd1);

    fill_pattern();
    run_board(1'b0, 1, 1'b1, 1'b0);
    fill_random();
    run_board(1'b1, 5, 1'b0, 1'b0);
    fill_random();
    run_board(1'b0, NEVER, 1'b0, 1'b0);
    fill_random();
    run_board(1'b1, TO + 1, 1'b0, 1'b0);
    run_reset_mid_load();
    fill_pattern();
    run_board(1'b0, 3, 1'b0, 1'b0);
    fill_random();
    run_board(1'b1, 4, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      fill_random();
      run_board(1'($urandom), $urandom_range(1, 20), 1'($urandom),
                1'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
